result_viewer: RTL and testbench
================================

# result_viewer

Downstream consumer of the convolution results memory. Once the compute FSM signals that all results are written, this block walks the results BRAM one word at a time. Two debounced push-buttons step forward and back through the entries, and each fetched 16-bit Q7.8 result drives the 16 board LEDs. The block owns the results-BRAM read port during display. It absorbs the BRAM read latency and the button bounce so that the compute FSM carries no display logic.

## Interface

Parameters:
- ADDR_W, 15: results BRAM address width.
- DATA_W, 16: result word width; must equal the LED width.
- NUM_RESULTS, 36: number of valid entries, at addresses 0..NUM_RESULTS-1.
- RD_LATENCY, 2: BRAM cycles from address register to valid `rd_data` (1..7).
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a button level change (≥2).

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: asynchronous, active-low reset.
- results_done, in, 1: one-cycle pulse from the compute FSM once the last result is written.
- btn_next, in, 1: raw, asynchronous push-button; advances to the next entry.
- btn_prev, in, 1: raw, asynchronous push-button; goes back to the previous entry.
- rd_addr, out, ADDR_W: results BRAM read address, registered.
- rd_data, in, DATA_W: results BRAM read data.
- LED, out, DATA_W: displayed value.
- cur_idx, out, ADDR_W: index of the entry currently displayed.
- busy, out, 1: high while a fetch is in flight.

## Operation

- **Button front end (per button)**
  - Two-flop synchronizer, then a debouncer.
  - The debounce counter resets whenever the synced level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced level.
  - A press pulse is one cycle on the debounced 0→1 transition.
  - Releases produce no pulse.
- **State machine (S_WAIT, S_FETCH, S_LAT, S_SHOW)**
  - **S_WAIT**
    - LED = 16'h0001; cur_idx = 0; button pulses are ignored.
    - On results_done: idx ← 0, go to S_FETCH.
  - **S_FETCH**
    - rd_addr ← idx; latency counter ← 0; busy = 1.
    - Go to S_LAT.
  - **S_LAT**
    - Counter increments each cycle.
    - When counter == RD_LATENCY-1: LED ← rd_data, cur_idx ← idx, go to S_SHOW.
  - **S_SHOW**
    - busy = 0; LED holds its value.
    - next pulse: idx ← idx+1, or 0 if idx == NUM_RESULTS-1 (wrap); go to S_FETCH.
    - prev pulse: idx ← idx-1, or NUM_RESULTS-1 if idx == 0 (wrap); go to S_FETCH.
    - next and prev pulses in the same cycle: both ignored, stay in S_SHOW.
- **Pulses during S_FETCH/S_LAT** are dropped. There is no queueing, and a press is never applied twice.
- **results_done outside S_WAIT** restarts the display: idx ← 0, go to S_FETCH. This covers a recomputed result set.
- **Reset values**
  - Outputs: rd_addr = 0, LED = 0, cur_idx = 0, busy = 0.
  - Internal: state = S_WAIT, synchronizers and debounced levels = 0, counters = 0.
  - The first cycle after reset release drives LED = 16'h0001.
- **Reset mid-fetch** discards the fetch. No LED update occurs after reset deasserts until the next results_done.
- **Address arithmetic**
  - idx is ADDR_W wide; comparisons use NUM_RESULTS-1 in ADDR_W bits.
  - rd_addr never leaves 0..NUM_RESULTS-1.
- **Data path:** rd_data passes to LED unmodified. There is no sign or format conversion.

## Timing

- Raw button edge to press pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycle, provided the input stays stable throughout.
- Press pulse (in S_SHOW) to LED update: 1 cycle in S_FETCH + RD_LATENCY cycles in S_LAT.
  - With the RD_LATENCY=2 default, LED changes on the 3rd rising edge after the pulse cycle.
- results_done to first LED value: 1 + RD_LATENCY cycles.
- busy is asserted from the cycle after the trigger until the cycle LED updates, inclusive of S_FETCH and S_LAT.
- rd_addr is stable from S_FETCH through the capture edge.
- LED and cur_idx update on the same edge. Between fetches, LED is glitch-free (registered).

## Test plan

In all scenarios, BRAM is modelled with RD_LATENCY=2, contents mem[i] = 16'h0100 + i, NUM_RESULTS=36, DEBOUNCE_CYCLES=4.

- **Start-up:** release rst, hold 10 cycles, pulse results_done → LED = 16'h0001 before the pulse; 3 cycles after the pulse LED = 16'h0100, cur_idx = 0, busy low.
- **Step and wrap:** 36 clean btn_next presses (each held 10 cycles) → LED = 16'h0101 … 16'h0123, then 16'h0100 with cur_idx = 0; one btn_prev press from idx 0 → LED = 16'h0123, cur_idx = 35.
- **Bounce rejection:** btn_next toggling every 2 cycles for 20 cycles, then held high for 8 cycles → exactly one advance; btn_next high for 3 cycles only → no advance.
- **Conflicts:**
  - btn_next and btn_prev debounced on the same cycle → LED and cur_idx unchanged.
  - btn_prev pulse forced during S_LAT → dropped; the result is the single intended fetch only.
- **Restart:** at idx 12, pulse results_done → fetch of idx 0, LED = 16'h0100 three cycles later.
- **Async reset mid-fetch:** assert rst between edges in S_LAT → LED, cur_idx, rd_addr and busy are 0 immediately (without waiting for a clock edge); after release LED = 16'h0001 and no stray capture occurs.

Source files
------------

// File: rtl/result_viewer.sv
// Steps through the convolution results BRAM once compute is done and shows each Q7.8 word on the LEDs.
// Two debounced buttons move forward/back with wrap; the BRAM read latency is absorbed by a small FSM.
module result_viewer #(
  parameter int ADDR_W          = 15,
  parameter int DATA_W          = 16,
  parameter int NUM_RESULTS     = 36,
  parameter int RD_LATENCY      = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              results_done,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] LED,
  output logic [ADDR_W-1:0] cur_idx,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_RESULTS - 1);
  localparam logic [2:0]        LAT_LAST = 3'(RD_LATENCY - 1);
  localparam logic [DATA_W-1:0] LED_IDLE = DATA_W'(1);

  typedef enum logic [1:0] {S_WAIT, S_FETCH, S_LAT, S_SHOW} state_t;

  function automatic logic [ADDR_W-1:0] idx_inc(input logic [ADDR_W-1:0] i);
    idx_inc = (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] idx_dec(input logic [ADDR_W-1:0] i);
    idx_dec = (i == '0) ? IDX_LAST : i - 1'b1;
  endfunction

  // bit 0 = next, bit 1 = prev
  logic [1:0]            raw;
  logic [1:0]            sync_p0;
  logic [1:0]            sync_p1;
  logic [1:0]            deb;
  logic [1:0]            press;
  logic [1:0][CNT_W-1:0] db_cnt;

  assign raw = {btn_prev, btn_next};

  // Synchronizer stages then debounce: the level must differ from the accepted one for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb     <= '0;
      press   <= '0;
      db_cnt  <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int b = 0; b < 2; b++) begin
        press[b] <= 1'b0;
        if (sync_p1[b] != deb[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            deb[b]    <= sync_p1[b];
            press[b]  <= sync_p1[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  logic next_go;
  logic prev_go;

  assign next_go = press[0] & ~press[1];
  assign prev_go = press[1] & ~press[0];

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [2:0]        lat_cnt;

  // Fetch sequencer; results_done restarts from entry 0 in any state and pre-empts a pending capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_WAIT;
      idx     <= '0;
      lat_cnt <= '0;
      rd_addr <= '0;
      LED     <= '0;
      cur_idx <= '0;
      busy    <= 1'b0;
    end else if (results_done) begin
      if (state == S_WAIT) begin
        LED     <= LED_IDLE;
        cur_idx <= '0;
      end
      idx   <= '0;
      busy  <= 1'b1;
      state <= S_FETCH;
    end else begin
      case (state)
        S_WAIT: begin
          LED     <= LED_IDLE;
          cur_idx <= '0;
        end
        S_FETCH: begin
          rd_addr <= idx;
          lat_cnt <= '0;
          state   <= S_LAT;
        end
        S_LAT: begin
          if (lat_cnt == LAT_LAST) begin
            LED     <= rd_data;
            cur_idx <= idx;
            busy    <= 1'b0;
            state   <= S_SHOW;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (next_go) begin
            idx   <= idx_inc(idx);
            busy  <= 1'b1;
            state <= S_FETCH;
          end else if (prev_go) begin
            idx   <= idx_dec(idx);
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_result_viewer.sv
// Bench for result_viewer: event-level reference model compared every cycle, directed scenarios
// with literal expectations, then a randomized button/results_done phase.
module tb_result_viewer;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int NUM    = 36;
  localparam int LAT    = 2;
  localparam int DB     = 4;

  logic              clk          = 1'b0;
  logic              rst          = 1'b1;
  logic              results_done = 1'b0;
  logic              btn_next     = 1'b0;
  logic              btn_prev     = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data      = '0;
  logic [DATA_W-1:0] LED;
  logic [ADDR_W-1:0] cur_idx;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  bit chk         = 1'b0;

  result_viewer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RESULTS(NUM),
    .RD_LATENCY(LAT), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .results_done(results_done),
    .btn_next(btn_next), .btn_prev(btn_prev),
    .rd_addr(rd_addr), .rd_data(rd_data), .LED(LED),
    .cur_idx(cur_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Results BRAM: address registered in the DUT plus one output register here gives latency 2
  always @(posedge clk) rd_data <= DATA_W'(32'h0100 + 32'(rd_addr));

  // ---------------- reference model ----------------
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_deb[2];
  bit          m_press[2];
  bit [DB-1:0] m_hist[2];
  bit          m_wait;
  int          m_rem;
  int          m_idx;
  int          m_led;
  int          m_cur;
  int          m_addr;
  bit          m_busy;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_press[b] = 0; m_hist[b] = '0;
    end
    m_wait = 1; m_rem = 0; m_idx = 0; m_led = 0; m_cur = 0; m_addr = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit np, pp, r;
    np = m_press[0];
    pp = m_press[1];
    for (int b = 0; b < 2; b++) begin
      r = (b == 0) ? btn_next : btn_prev;
      m_hist[b]  = {m_hist[b][DB-2:0], m_s2[b]};
      m_press[b] = 0;
      if (m_hist[b] == (m_deb[b] ? {DB{1'b0}} : {DB{1'b1}})) begin
        m_deb[b]   = ~m_deb[b];
        m_press[b] = m_deb[b];
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = r;
    end
    if (m_wait) begin
      m_led = 1;
      m_cur = 0;
    end
    if (results_done) begin
      m_wait = 0; m_idx = 0; m_rem = LAT + 1; m_busy = 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == LAT) m_addr = m_idx;
      if (m_rem == 0) begin
        m_led = 32'h0100 + m_idx;
        m_cur = m_idx;
        m_busy = 0;
      end
    end else if (!m_wait && np != pp) begin
      m_idx  = np ? (m_idx + 1) % NUM : (m_idx + NUM - 1) % NUM;
      m_rem  = LAT + 1;
      m_busy = 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("led",     32'(LED),     32'(m_led));
      check("cur_idx", 32'(cur_idx), 32'(m_cur));
      check("busy",    32'(busy),    32'(m_busy));
      check("rd_addr", 32'(rd_addr), 32'(m_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit nxt, input bit prv, input int hold);
    btn_next = nxt;
    btn_prev = prv;
    tick(hold);
    btn_next = 0;
    btn_prev = 0;
    tick(12);
  endtask

  initial begin
    int guard;
    #1 rst = 0;
    chk = 1;
    tick(3);
    check("rst_led",  32'(LED),     32'h0);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_addr", 32'(rd_addr), 32'h0);
    rst = 1;
    tick(10);
    check("idle_led", 32'(LED), 32'h0001);

    // start-up
    results_done = 1;
    tick(1);
    results_done = 0;
    tick(3);
    check("start_led",  32'(LED),     32'h0100);
    check("start_cur",  32'(cur_idx), 32'h0);
    check("start_busy", 32'(busy),    32'h0);

    // step forward through every entry and wrap
    for (int i = 1; i <= NUM; i++) begin
      press(1, 0, 10);
      check("step_led", 32'(LED),     32'h0100 + 32'(i % NUM));
      check("step_cur", 32'(cur_idx), 32'(i % NUM));
    end
    press(0, 1, 10);
    check("wrap_back_led", 32'(LED),     32'h0123);
    check("wrap_back_cur", 32'(cur_idx), 32'd35);

    // bounce: toggles of 2 cycles are rejected, then a stable hold gives one advance
    for (int k = 0; k < 10; k++) begin
      btn_next = (k % 2 == 0);
      tick(2);
    end
    btn_next = 1;
    tick(8);
    btn_next = 0;
    tick(12);
    check("bounce_cur", 32'(cur_idx), 32'd0);
    btn_next = 1;
    tick(3);
    btn_next = 0;
    tick(12);
    check("short_cur", 32'(cur_idx), 32'd0);

    // both buttons accepted on the same cycle
    press(1, 1, 10);
    check("both_cur", 32'(cur_idx), 32'd0);
    check("both_led", 32'(LED),     32'h0100);

    // prev pulse lands while the next fetch is in its latency phase
    btn_next = 1;
    tick(2);
    btn_prev = 1;
    tick(10);
    btn_next = 0;
    btn_prev = 0;
    tick(12);
    check("drop_cur", 32'(cur_idx), 32'd1);
    check("drop_led", 32'(LED),     32'h0101);

    // restart from idx 12
    guard = 0;
    while (m_cur != 12 && guard < 40) begin
      press(1, 0, 10);
      guard++;
    end
    check("at12_cur", 32'(cur_idx), 32'd12);
    results_done = 1;
    tick(1);
    results_done = 0;
    tick(3);
    check("restart_led", 32'(LED),     32'h0100);
    check("restart_cur", 32'(cur_idx), 32'd0);

    // randomized buttons and occasional recompute pulses
    for (int it = 0; it < 200; it++) begin
      results_done = ($urandom_range(0, 15) == 0);
      tick(1);
      results_done = 0;
      btn_next = 1'($urandom_range(0, 1));
      btn_prev = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 12));
    end
    btn_next = 0;
    btn_prev = 0;
    tick(15);
    results_done = 1;
    tick(1);
    results_done = 0;
    tick(12);

    // asynchronous reset in the latency phase of a fetch
    btn_next = 1;
    tick(8);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #1 rst = 0;
    #1;
    check("arst_led",  32'(LED),     32'h0);
    check("arst_cur",  32'(cur_idx), 32'h0);
    check("arst_addr", 32'(rd_addr), 32'h0);
    check("arst_busy", 32'(busy),    32'h0);
    tick(2);
    rst = 1;
    btn_next = 0;
    tick(1);
    check("post_rst_led", 32'(LED), 32'h0001);
    tick(10);
    check("no_stray_led",  32'(LED),  32'h0001);
    check("no_stray_busy", 32'(busy), 32'h0);

    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
